// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division on magnitudes,
// with sign correction applied on the final iteration.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies finish as soon
// as the remaining multiplier bits are all zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
    logic [2*WIDTH-1:0] mcand;    // shifted multiplicand
    logic [WIDTH-1:0]   mplr;     // multiplier (shifted) or divisor
    logic               is_div;
    logic               neg_lo;   // negate product / quotient
    logic               neg_hi;   // negate remainder
    logic               dz;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] iter_acc;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               last;

    assign hi = hi_r;
    assign lo = lo_r;

    // Operand magnitudes and one iteration of the selected algorithm.
    always_comb begin
        accept    = start && (state != StRun);
        a_neg     = !op[0] && a[WIDTH-1];
        b_neg     = !op[0] && b[WIDTH-1];
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
        mul_acc   = mplr[0] ? (acc + mcand) : acc;
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mplr};
        // A borrow out of the subtraction means the shifted remainder is below the divisor.
        div_ge    = !div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {acc[WIDTH-2:0], div_ge};
        iter_acc  = is_div ? {div_rem, div_quo} : mul_acc;
        mul_res   = neg_lo ? (~iter_acc + 1'b1) : iter_acc;
        res_lo    = is_div ? (neg_lo ? (~div_quo + 1'b1) : div_quo) : mul_res[WIDTH-1:0];
        res_hi    = is_div ? (neg_hi ? (~div_rem + 1'b1) : div_rem) : mul_res[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
        last      = (cnt == CW'(1)) || (!is_div && (mplr[WIDTH-1:1] == '0));
`else
        last      = (cnt == CW'(1));
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        case (state)
            StIdle: begin
                if (start) state_next = StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (dz || last) state_next = StDone;
            end
            StDone: begin
                done        = 1'b1;
                div_by_zero = dz;
                state_next  = start ? StRun : StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    // Datapath: operand load, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else if (accept) begin
            cnt    <= CW'(WIDTH);
            is_div <= op[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            dz     <= op[1] && (b == '0);
            mplr   <= b_mag;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            if (!op[1]) begin
                acc <= '0;
            end else if (b == '0) begin
                // Divide-by-zero result is staged directly in the accumulator.
                acc <= {a, {WIDTH{1'b1}}};
            end else begin
                acc <= {{WIDTH{1'b0}}, a_mag};
            end
        end else if (state == StRun) begin
            if (dz) begin
                hi_r <= acc[2*WIDTH-1:WIDTH];
                lo_r <= acc[WIDTH-1:0];
            end else if (last) begin
                hi_r <= res_hi;
                lo_r <= res_lo;
            end else begin
                acc   <= iter_acc;
                mcand <= mcand << 1;
                mplr  <= is_div ? mplr : (mplr >> 1);
                cnt   <= cnt - CW'(1);
            end
        end else begin
            if (hi_we) hi_r <= wdata;
            if (lo_we) lo_r <= wdata;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int L_M1 = 1, L_B3 = 2, L_B7 = 3;
`else
    localparam int L_M1 = 32, L_B3 = 32, L_B7 = 32;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    int   cyc = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no pending operation");
                end else begin
                    e = sb.pop_front();
                    chk("sb_hi", hi, e.hi);
                    chk("sb_lo", lo, e.lo);
                    chk("sb_dz", {31'b0, div_by_zero}, {31'b0, e.dz});
                    chk("sb_latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_done(input int n0, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (ndone != n0) seen = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_timeout"}, {31'b0, seen}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int lat, input string nm);
        exp_t e;
        int   n0;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        e.hi = eh; e.lo = el; e.dz = edz; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        n0 = ndone;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0, nm);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100us");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32, "multu_ff");
        issue(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, L_M1, "mult_ff");
        issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'hFFFFFFFD, 1'b0, L_B3, "multu_b3");
        issue(OP_MULT,  32'hFFFFFFFA, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, L_B7, "mult_neg");
        issue(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, "div_neg");
        issue(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 32, "divu");
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32, "div_ovf");
        issue(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 32, "div_negb");
        issue(OP_DIVU,  32'h1234,     32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1, "divu_zero");
        @(negedge clk);
        chk("dz_pulse_done_low", {31'b0, done}, 32'd0);
        chk("dz_pulse_dz_low", {31'b0, div_by_zero}, 32'd0);

        // Collision: start and MTHI while busy must both be ignored.
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0; e.cyc = cyc + 33;
        sb.push_back(e);
        n0 = ndone;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9; hi_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("coll_busy", {31'b0, busy}, 32'd1);
        chk("coll_hi_hold", hi, 32'h1234);
        chk("coll_lo_hold", lo, 32'hFFFFFFFF);
        wait_done(n0, "coll_divu");
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'hAA);
        chk("mthi_lo_kept", lo, 32'd14);
        lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h55);
        chk("mtlo_hi_kept", hi, 32'hAA);
        repeat (3) @(negedge clk);
        chk("coll_single_done", 32'(ndone), 32'(n0 + 1));
        chk("coll_idle", {31'b0, busy}, 32'd0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        op = OP_MULTU; a = 32'd5; b = 32'd7; start = 1'b1;
        n0 = ndone;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 32'(ndone), 32'(n0));
        chk("midrst_hi_after", hi, 32'h0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU. Takes the same forwarded operands (A = rs, B = rt) from the ID/EX register.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers.
- HI/LO feed the EX result mux for MFHI/MFLO.
- Raises busy so the hazard unit stalls IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is supported; the counter is sized $clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin operation; sampled only when idle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  32  operand rs (multiplicand / dividend)
- b  in  32  operand rt (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- div_by_zero  out  1  pulses with done when a DIV/DIVU had b == 0
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset, asynchronous: state IDLE; hi = lo = 0; busy = done = div_by_zero = 0. Any operation in flight is aborted and its result discarded.

States and transitions:
- IDLE: start=1 at edge k latches operands and op, goes to RUN. Counter = 32. busy = 1 from edge k.
- RUN: one iteration per cycle, counter decrements.
- At the edge where counter reaches 0, final sign correction is applied combinationally. HI/LO are written, the unit goes to DONE and busy drops.
- DONE: done = 1 for exactly one cycle, then IDLE. A start in DONE is accepted exactly as in IDLE.
- Latency: start at edge k gives HI/LO valid and done = 1 after edge k+32. busy is high for 32 cycles.

Multiply:
- Shift-add: 64-bit product, {HI,LO}.
- MULT takes magnitudes of a and b and negates the 64-bit result if the signs differ.
- MULTU is unsigned.
- Examples: 0xFFFFFFFF*0xFFFFFFFF gives HI = 0xFFFFFFFE, LO = 0x00000001 (MULTU); HI = 0, LO = 1 (MULT).

Divide:
- Restoring division on magnitudes. LO = quotient, HI = remainder.
- DIV: quotient is negated if the signs differ. Remainder sign follows the dividend.
- Overflow 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0.

Divide by zero (b == 0, DIV or DIVU):
- No iteration; completes at edge k+1.
- LO = 0xFFFFFFFF, HI = a.
- done and div_by_zero pulse for one cycle.

Other boundary conditions:
- start while busy is ignored. Operands/op are not re-sampled.
- hi_we/lo_we in IDLE/DONE: register written at the next edge, no done pulse.
- hi_we/lo_we while busy: ignored.
- hi_we/lo_we in the same cycle as an accepted start: the write is dropped and the start wins.
- hi/lo outputs hold their last value throughout RUN. Intermediate state lives in internal registers only.
- reset asserted mid-RUN: returns to IDLE immediately with hi = lo = 0. No done pulse.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN
- Defined: in RUN, multiply terminates at the first edge where the remaining multiplier bits are all zero. The result is written at that edge and DONE follows.
  - Latency = 1 + index of the highest set bit of |b|, minimum 1 cycle (b == 0 gives product 0 at edge k+1).
  - Divide timing is unchanged.
- Undefined: fixed 32-cycle latency for all non-zero-divisor operations. Early-out logic is absent.

Test Plan:
- Reset mid-RUN: MULTU a=5, b=7, assert reset at edge k+10 -> hi = lo = 0, busy = 0 immediately, no done.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 32 cycles, HI = 0xFFFFFFFE, LO = 0x00000001. With MULDIV_EARLY_OUT_EN, same result in 32 cycles; b=3 finishes in 2 cycles with LO = 0x2FFFFFFFD truncated (HI = 0x00000002, LO = 0xFFFFFFFD).
- MULT a=-6 (0xFFFFFFFA), b=7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFD6 (-42).
- DIV a=-7, b=2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU a=100, b=7 -> LO = 14, HI = 2.
- DIVU a=0x1234, b=0 -> at edge k+1: LO = 0xFFFFFFFF, HI = 0x1234, done = div_by_zero = 1 for one cycle.
- Busy collision: start DIVU, then start MULT plus hi_we with wdata=0xAA at cycle k+5 -> both ignored, DIVU result delivered at k+32. Then hi_we with wdata=0xAA in IDLE -> hi = 0xAA next edge, no done.
